// File: rtl/taus_pkg.sv
// taus_pkg: shared constants, seed defaults and FSM state type for the
// dual taus88 uniform generator (taus_urng / taus88_core).
package taus_pkg;

    // Default component seeds for generators A and B.
    localparam logic [31:0] DEF_SEED_A1 = 32'd12345;
    localparam logic [31:0] DEF_SEED_A2 = 32'd23456;
    localparam logic [31:0] DEF_SEED_A3 = 32'd34567;
    localparam logic [31:0] DEF_SEED_B1 = 32'd45678;
    localparam logic [31:0] DEF_SEED_B2 = 32'd56789;
    localparam logic [31:0] DEF_SEED_B3 = 32'd67890;

    // Per-component step constants:
    //   s' = ((s & MASK) << SH_C) ^ (((s << SH_A) ^ s) >> SH_B)
    localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
    localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;
    localparam int SH_A1 = 13;
    localparam int SH_B1 = 19;
    localparam int SH_C1 = 12;
    localparam int SH_A2 = 2;
    localparam int SH_B2 = 25;
    localparam int SH_C2 = 4;
    localparam int SH_A3 = 3;
    localparam int SH_B3 = 11;
    localparam int SH_C3 = 17;

    // Sanitise ORs: force a set bit above each mask so no component can
    // start below the taus88 minimum seed (and a zero seed cannot lock up).
    localparam logic [31:0] SAN_OR1 = 32'h0000_0002;
    localparam logic [31:0] SAN_OR2 = 32'h0000_0008;
    localparam logic [31:0] SAN_OR3 = 32'h0000_0010;

    // Generator operating phase.
    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // One taus88 component step; all shifts are logical on 32 bits.
    function automatic logic [31:0] taus_comp(
        input logic [31:0] s,
        input logic [31:0] mask,
        input int          sh_a,
        input int          sh_b,
        input int          sh_c
    );
        logic [31:0] fb;
        fb = ((s << sh_a) ^ s) >> sh_b;
        return ((s & mask) << sh_c) ^ fb;
    endfunction

endpackage

// File: rtl/taus88_core.sv
// taus88_core: one three-component taus88 generator. Holds s1..s3, advances
// when adv=1, and accepts a per-component sanitised load (load wins).
// The output is the combinational XOR of the next-state values.
module taus88_core
    import taus_pkg::*;
#(
    parameter logic [31:0] SEED1 = DEF_SEED_A1,
    parameter logic [31:0] SEED2 = DEF_SEED_A2,
    parameter logic [31:0] SEED3 = DEF_SEED_A3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [2:0]  load_en,
    input  logic [31:0] load_data,
    output logic [31:0] out
);

    logic [31:0] s1, s2, s3;
    logic [31:0] n1, n2, n3;

    // Next-state of each component and the generator output.
    always_comb begin
        n1  = taus_comp(s1, MASK1, SH_A1, SH_B1, SH_C1);
        n2  = taus_comp(s2, MASK2, SH_A2, SH_B2, SH_C2);
        n3  = taus_comp(s3, MASK3, SH_A3, SH_B3, SH_C3);
        out = n1 ^ n2 ^ n3;
    end

    // State registers: reset to sanitised parameter seeds, load, or advance.
    // NOTE: non-blocking assignments so every register samples the pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= SEED1 | SAN_OR1;
            s2 <= SEED2 | SAN_OR2;
            s3 <= SEED3 | SAN_OR3;
        end else begin
            if (load_en[0])  s1 <= load_data | SAN_OR1;
            else if (adv)    s1 <= n1;
            if (load_en[1])  s2 <= load_data | SAN_OR2;
            else if (adv)    s2 <= n2;
            if (load_en[2])  s3 <= load_data | SAN_OR3;
            else if (adv)    s3 <= n3;
        end
    end

endmodule

// File: rtl/taus_urng.sv
// taus_urng: dual taus88 uniform generator feeding Box-Muller.
// u0 = {outA, outB[31:16]}, u1 = outB[15:0]. A warm-up phase of WARMUP
// advances runs after reset or reseed before valid asserts.
// Optional runtime reseeding is compiled in with `define TAUS_SEED_LOAD_EN.
module taus_urng
    import taus_pkg::*;
#(
    parameter logic [31:0] SEED_A1 = DEF_SEED_A1,
    parameter logic [31:0] SEED_A2 = DEF_SEED_A2,
    parameter logic [31:0] SEED_A3 = DEF_SEED_A3,
    parameter logic [31:0] SEED_B1 = DEF_SEED_B1,
    parameter logic [31:0] SEED_B2 = DEF_SEED_B2,
    parameter logic [31:0] SEED_B3 = DEF_SEED_B3,
    parameter int          WARMUP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
`ifdef TAUS_SEED_LOAD_EN
    input  logic        seed_we,
    input  logic [2:0]  seed_addr,
    input  logic [31:0] seed_data,
`endif
    output logic [47:0] u0,
    output logic [15:0] u1,
    output logic        valid
);

    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        seed_hit;
    logic        advance;
    logic [2:0]  load_en_a, load_en_b;
    logic [31:0] load_data;
    logic [31:0] out_a, out_b;

`ifdef TAUS_SEED_LOAD_EN
    // Seed-address decode; addresses 6 and 7 are not a write at all.
    always_comb begin
        load_en_a = 3'b000;
        load_en_b = 3'b000;
        seed_hit  = seed_we && (seed_addr <= 3'd5);
        load_data = seed_data;
        if (seed_hit) begin
            case (seed_addr)
                3'd0:    load_en_a = 3'b001;
                3'd1:    load_en_a = 3'b010;
                3'd2:    load_en_a = 3'b100;
                3'd3:    load_en_b = 3'b001;
                3'd4:    load_en_b = 3'b010;
                default: load_en_b = 3'b100;
            endcase
        end
    end
`else
    // No runtime reseeding: load ports are tied off.
    always_comb begin
        seed_hit  = 1'b0;
        load_en_a = 3'b000;
        load_en_b = 3'b000;
        load_data = 32'd0;
    end
`endif

    // Advance every cycle in warm-up, on en in run; a seed write blocks it.
    always_comb begin
        advance = !seed_hit && ((state == ST_WARMUP) || en);
    end

    taus88_core #(
        .SEED1 (SEED_A1),
        .SEED2 (SEED_A2),
        .SEED3 (SEED_A3)
    ) u_gen_a (
        .clk       (clk),
        .rst       (reset),
        .adv       (advance),
        .load_en   (load_en_a),
        .load_data (load_data),
        .out       (out_a)
    );

    taus88_core #(
        .SEED1 (SEED_B1),
        .SEED2 (SEED_B2),
        .SEED3 (SEED_B3)
    ) u_gen_b (
        .clk       (clk),
        .rst       (reset),
        .adv       (advance),
        .load_en   (load_en_b),
        .load_data (load_data),
        .out       (out_b)
    );

    // Phase FSM and warm-up counter; valid is registered alongside state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WARMUP;
            cnt   <= 8'd0;
            valid <= 1'b0;
        end else if (seed_hit) begin
            state <= ST_WARMUP;
            cnt   <= 8'd0;
            valid <= 1'b0;
        end else if (state == ST_WARMUP) begin
            if (cnt == WARMUP_LAST) begin
                state <= ST_RUN;
                cnt   <= 8'd0;
                valid <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Output registers capture the fresh pair on every advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u0 <= 48'd0;
            u1 <= 16'd0;
        end else if (advance) begin
            u0 <= {out_a, out_b[31:16]};
            u1 <= out_b[15:0];
        end
    end

endmodule

// File: tb/tb_taus_urng.sv
// tb_taus_urng: directed self-checking bench for taus_urng (default params).
// Expected samples come from a taus88 model written from the step equations.
module tb_taus_urng;

    logic        clk;
    logic        reset;
    logic        en;
    logic [47:0] u0;
    logic [15:0] u1;
    logic        valid;
`ifdef TAUS_SEED_LOAD_EN
    logic        seed_we;
    logic [2:0]  seed_addr;
    logic [31:0] seed_data;
`endif

    int vectors;
    int miscompares;

    // Model state and expected outputs.
    logic [31:0] ma1, ma2, ma3, mb1, mb2, mb3;
    logic [47:0] exp_u0;
    logic [15:0] exp_u1;
    logic [47:0] prev_u0;

    taus_urng dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
`ifdef TAUS_SEED_LOAD_EN
        .seed_we   (seed_we),
        .seed_addr (seed_addr),
        .seed_data (seed_data),
`endif
        .u0        (u0),
        .u1        (u1),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] st1(input logic [31:0] s);
        return ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction
    function automatic logic [31:0] st2(input logic [31:0] s);
        return ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction
    function automatic logic [31:0] st3(input logic [31:0] s);
        return ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    task automatic model_reset();
        ma1 = 32'd12345 | 32'h2;
        ma2 = 32'd23456 | 32'h8;
        ma3 = 32'd34567 | 32'h10;
        mb1 = 32'd45678 | 32'h2;
        mb2 = 32'd56789 | 32'h8;
        mb3 = 32'd67890 | 32'h10;
    endtask

    task automatic model_advance();
        logic [31:0] oa, ob;
        ma1 = st1(ma1); ma2 = st2(ma2); ma3 = st3(ma3);
        mb1 = st1(mb1); mb2 = st2(mb2); mb3 = st3(mb3);
        oa = ma1 ^ ma2 ^ ma3;
        ob = mb1 ^ mb2 ^ mb3;
        exp_u0 = {oa, ob[31:16]};
        exp_u1 = ob[15:0];
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic exp_valid);
        check({tag, ".u0"}, 64'(u0), 64'(exp_u0));
        check({tag, ".u1"}, 64'(u1), 64'(exp_u1));
        check({tag, ".valid"}, 64'(valid), 64'(exp_valid));
    endtask

    // Warm-up of 8 edges with en=0: valid must rise on the 8th edge only.
    task automatic warmup_seq(input string tag);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            model_advance();
            check_out(tag, (i == 7));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        en          = 1'b0;
`ifdef TAUS_SEED_LOAD_EN
        seed_we     = 1'b0;
        seed_addr   = 3'd0;
        seed_data   = 32'd0;
`endif
        model_reset();
        exp_u0 = 48'd0;
        exp_u1 = 16'd0;

        // Reset state.
        tick();
        check_out("reset", 1'b0);

        // Release and warm up.
        reset = 1'b0;
        warmup_seq("warmup");

        // Golden stream.
        en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            model_advance();
            check_out("golden", 1'b1);
        end

        // Stall: outputs hold, valid stays high, then next sample with no skip.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stall", 1'b1);
        end
        en = 1'b1;
        tick();
        model_advance();
        check_out("resume", 1'b1);
        tick();
        model_advance();
        check_out("resume2", 1'b1);

        // Asynchronous reset mid-run: zeros without waiting for an edge.
        #2;
        reset = 1'b1;
        #1;
        exp_u0 = 48'd0;
        exp_u1 = 16'd0;
        check_out("async_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        warmup_seq("rewarm");

`ifdef TAUS_SEED_LOAD_EN
        // Zero seed to A1 with en=1 on the same edge: write wins, no advance.
        en        = 1'b1;
        seed_we   = 1'b1;
        seed_addr = 3'd0;
        seed_data = 32'd0;
        tick();
        seed_we = 1'b0;
        ma1 = 32'h0000_0002;
        check_out("seed_prio", 1'b0);
        check("seed_a1", 64'(dut.u_gen_a.s1), 64'h2);

        // Warm-up after reseed; output must keep changing.
        prev_u0 = u0;
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            model_advance();
            check_out("seed_warm", (i == 7));
            check("seed_moving", 64'(u0 != prev_u0), 64'd1);
            prev_u0 = u0;
        end

        // Write to address 7 is ignored: no state change, valid stays high.
        seed_we   = 1'b1;
        seed_addr = 3'd7;
        seed_data = 32'hDEAD_BEEF;
        tick();
        seed_we = 1'b0;
        check_out("addr7", 1'b1);
        en = 1'b1;
        tick();
        model_advance();
        check_out("addr7_next", 1'b1);
        en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
